uart_command_receiver: RTL

- Host-to-FPGA control path for the time-tagger: receives 8N1 UART bytes on the serial rx line and decodes single-byte host commands into control levels and pulses (activate, counter reset, channel mask).
- Complements the tagger's record-transmit path. It shares that path's bit timing (CLKS_PER_BIT) and the same single clock domain.
- Raw received bytes are also exposed with a one-cycle valid strobe for debug/loopback.

---
 rtl/uart_command_receiver.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_command_receiver.sv
// uart_command_receiver: 8N1 UART receiver that decodes single-byte host commands
// into activate/counter_reset/channel_mask controls, exposing raw bytes for loopback.
module uart_command_receiver #(
  parameter int         CLKS_PER_BIT     = 173,
  parameter int         ARG_TIMEOUT_CLKS = 3460,
  parameter logic [3:0] MASK_RESET       = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       activate,
  output logic       counter_reset,
  output logic [3:0] channel_mask,
  output logic       cmd_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(ARG_TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(ARG_TIMEOUT_CLKS);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HIGH} rx_state_t;
  typedef enum logic {D_IDLE, D_ARG} cmd_state_t;
  rx_state_t rx_state, rx_state_n;
  cmd_state_t cmd_state, cmd_state_n;
  logic rx_s1, rx_s2, rx_q;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, rx_byte_n;
  logic rx_valid_n, frame_error_n;
  logic [TW-1:0] tmo, tmo_n;
  logic activate_n, counter_reset_n, cmd_error_n;
  logic [3:0] mask_n;
  logic line;
  assign line = rx_s2;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_q        <= 1'b1;
      rx_state    <= R_IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_s1       <= rx_in;
      rx_s2       <= rx_s1;
      rx_q        <= rx_s2;
      rx_state    <= rx_state_n;
      clk_cnt     <= clk_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      rx_byte     <= rx_byte_n;
      rx_valid    <= rx_valid_n;
      frame_error <= frame_error_n;
    end
  always_comb begin
    rx_state_n    = rx_state;
    clk_cnt_n     = clk_cnt;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    rx_byte_n     = rx_byte;
    rx_valid_n    = 1'b0;
    frame_error_n = 1'b0;
    case (rx_state)
      R_IDLE:
        if (rx_q && !line) begin
          rx_state_n = R_START;
          clk_cnt_n  = '0;
          bit_cnt_n  = '0;
        end
      R_START:
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_n  = '0;
          rx_state_n = line ? R_IDLE : R_DATA;
        end else clk_cnt_n = clk_cnt + 1'b1;
      R_DATA:
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n  = '0;
          shift_n    = {line, shift[7:1]};
          bit_cnt_n  = bit_cnt + 1'b1;
          rx_state_n = (bit_cnt == 3'd7) ? R_STOP : R_DATA;
        end else clk_cnt_n = clk_cnt + 1'b1;
      R_STOP:
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n     = '0;
          rx_byte_n     = line ? shift : rx_byte;
          rx_valid_n    = line;
          frame_error_n = !line;
          rx_state_n    = line ? R_IDLE : R_WAIT_HIGH;
        end else clk_cnt_n = clk_cnt + 1'b1;
      R_WAIT_HIGH: rx_state_n = line ? R_IDLE : R_WAIT_HIGH;
      default: rx_state_n = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cmd_state     <= D_IDLE;
      tmo           <= '0;
      activate      <= 1'b0;
      counter_reset <= 1'b0;
      channel_mask  <= MASK_RESET;
      cmd_error     <= 1'b0;
    end else begin
      cmd_state     <= cmd_state_n;
      tmo           <= tmo_n;
      activate      <= activate_n;
      counter_reset <= counter_reset_n;
      channel_mask  <= mask_n;
      cmd_error     <= cmd_error_n;
    end
  // A byte arriving in ARG takes priority over a timeout expiring in the same cycle.
  always_comb begin
    cmd_state_n     = cmd_state;
    tmo_n           = tmo;
    activate_n      = activate;
    counter_reset_n = 1'b0;
    mask_n          = channel_mask;
    cmd_error_n     = 1'b0;
    if (cmd_state == D_IDLE) begin
      if (rx_valid) begin
        if (rx_byte == 8'h41) activate_n = 1'b1;
        else if (rx_byte == 8'h53) activate_n = 1'b0;
        else if (rx_byte == 8'h52) begin
          activate_n      = 1'b0;
          counter_reset_n = 1'b1;
        end else if (rx_byte == 8'h4D) begin
          cmd_state_n = D_ARG;
          tmo_n       = TMO_LOAD;
        end else cmd_error_n = 1'b1;
      end
    end else begin
      tmo_n = (tmo != '0) ? tmo - 1'b1 : tmo;
      if (rx_valid) begin
        cmd_state_n = D_IDLE;
        mask_n      = (rx_byte[7:4] == 4'h0) ? rx_byte[3:0] : channel_mask;
        cmd_error_n = (rx_byte[7:4] != 4'h0);
      end else if (frame_error || tmo <= TW'(1)) begin
        cmd_state_n = D_IDLE;
        cmd_error_n = 1'b1;
      end
    end
  end
endmodule
